// File: rtl/regwb_arbiter.sv
// regwb_arbiter
// Arbitrates the register file's single write port between the in-order
// writeback stage and one long-latency unit. It also keeps a scoreboard of
// registers with long-latency writes still pending, which decode checks for
// hazards. Writeback wins by default. A starvation counter forces the
// long-latency result through, stalling writeback for one cycle.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   wb_we/wb_waddr/wb_wdata           pipeline writeback request
//   wb_stall                          writeback refused this cycle (hold and re-present)
//   lu_valid/lu_waddr/lu_wdata        long-latency result
//   lu_ready                          long-latency result accepted this cycle
//   lu_issue/lu_issue_addr            decode issues a long-latency op (marks dest busy)
//   re1/raddr_1, re2/raddr_2          decode read ports to hazard-check
//   dst_chk/dst_addr                  decode destination to hazard-check (WAW)
//   hazard_stall                      decode must stall
//   we/waddr/wdata                    register file write port
module regwb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              wb_stall,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    output logic              lu_ready,
    input  logic              lu_issue,
    input  logic [ADDR_W-1:0] lu_issue_addr,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    input  logic              dst_chk,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              hazard_stall,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FORCE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREG-1:0]   r_busy;

    logic              w_wb_active;
    logic              w_handshake;
    logic              w_refused;
    logic [NREG-1:0]   w_busy_nxt;

    // A writeback to r0 is a no-op, so it never competes for the port.
    assign w_wb_active = wb_we & (wb_waddr != '0);
    assign w_handshake = lu_valid & lu_ready;
    assign w_refused   = lu_valid & ~lu_ready;

    // Write-port mux and handshakes. All outputs are held low during reset.
    always_comb begin
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        lu_ready = 1'b0;
        wb_stall = 1'b0;
        if (!rst) begin
            if (r_state == S_FORCE) begin
                lu_ready = 1'b1;
                wb_stall = 1'b1;
                we       = lu_valid & (lu_waddr != '0);
                waddr    = lu_waddr;
                wdata    = lu_wdata;
            end else begin
                lu_ready = lu_valid & ~w_wb_active;
                if (w_wb_active) begin
                    we    = 1'b1;
                    waddr = wb_waddr;
                    wdata = wb_wdata;
                end else if (lu_valid) begin
                    // An r0 result is still accepted, just not written.
                    we    = lu_waddr != '0;
                    waddr = lu_waddr;
                    wdata = lu_wdata;
                end
            end
        end
    end

    // Scoreboard next value: an issue to the same register wins over a completion.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_handshake) w_busy_nxt[lu_waddr] = 1'b0;
        if (lu_issue)    w_busy_nxt[lu_issue_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Uses the registered busy bits only, so a clear in this cycle releases readers next cycle.
    assign hazard_stall = ~rst & ((re1 & r_busy[raddr_1]) |
                                  (re2 & r_busy[raddr_2]) |
                                  (dst_chk & r_busy[dst_addr]));

    // Starvation FSM: cnt counts consecutive refused cycles of one pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_refused) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= (STARVE_LIMIT == 1) ? S_FORCE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A dropped lu_valid is a protocol violation; recover to IDLE.
                    if (lu_ready || !lu_valid) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(STARVE_LIMIT - 1)) r_state <= S_FORCE;
                    end
                end
                S_FORCE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/regwb_arbiter.md
# regwb_arbiter

Write-port arbiter and scoreboard for the 32×32 register file. It shares the register file's single write port between the in-order pipeline writeback stage and one long-latency unit (divider or multi-cycle load path). It also tracks destination registers that still have long-latency writes pending, and raises a hazard stall when the decode stage reads or targets one of them. A starvation counter forces a long-latency write through by stalling writeback.

## Interface
- STARVE_LIMIT, 4: cycles a valid long-latency write may be refused before writeback is forced to yield (1..15).
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_we  in  1  pipeline writeback write request
- wb_waddr  in  ADDR_W  pipeline writeback destination
- wb_wdata  in  DATA_W  pipeline writeback data
- wb_stall  out  1  writeback not performed this cycle; the pipeline holds and re-presents the same wb_* next cycle
- lu_valid  in  1  long-latency unit has a result
- lu_waddr  in  ADDR_W  long-latency destination
- lu_wdata  in  DATA_W  long-latency data
- lu_ready  out  1  long-latency result accepted this cycle
- lu_issue  in  1  decode issues a long-latency op this cycle
- lu_issue_addr  in  ADDR_W  destination of the issued op
- re1, re2  in  1  decode read-port enables
- raddr_1, raddr_2  in  ADDR_W  decode read addresses
- dst_chk  in  1  decode instruction writes a register
- dst_addr  in  ADDR_W  decode destination (WAW check)
- hazard_stall  out  1  decode must stall
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data

## Operation
- wb_active = wb_we & (wb_waddr != 0).
- States: IDLE, WAIT, FORCE. There is also a wait counter, cnt, 4 bits wide.
- **IDLE/WAIT write selection:**
  - lu_ready = lu_valid & ~wb_active.
  - If wb_active, the write port carries wb_*.
  - Else if lu_valid, it carries lu_*.
  - Else we=0.
  - wb_stall=0.
- **FORCE write selection:**
  - lu_ready=1, wb_stall=1.
  - The write port carries lu_*.
- **Transitions:**
  - IDLE→WAIT when lu_valid & ~lu_ready; cnt←1.
  - WAIT: if lu_ready, go to IDLE with cnt←0. Else if ~lu_valid (protocol violation), go to IDLE with cnt←0. Else cnt←cnt+1.
  - WAIT→FORCE when a refused cycle occurs with cnt==STARVE_LIMIT-1. In that cycle cnt reaches STARVE_LIMIT.
  - FORCE→IDLE unconditionally; cnt←0.
  - STARVE_LIMIT=1 goes IDLE→FORCE directly on the first refusal.
- **Long-latency protocol:** once raised, lu_valid and lu_* stay stable until the cycle in which lu_ready=1.
- **Writes to r0:**
  - A long-latency write to r0 is accepted (lu_ready=1) with we=0.
  - A writeback to r0 never blocks the long-latency unit.
- **Scoreboard:** a busy[31:0] vector, with busy[0] hard-wired to 0.
  - Set busy[lu_issue_addr] on lu_issue.
  - Clear busy[lu_waddr] on the handshake lu_valid & lu_ready.
  - Same register set and cleared in the same cycle: set wins.
- **hazard_stall** (combinational) = (re1 & busy[raddr_1]) | (re2 & busy[raddr_2]) | (dst_chk & busy[dst_addr]).
  - It does not reflect a clear happening in the same cycle.
  - The dst check ensures only one pending write per register.

## Timing
- we/waddr/wdata, lu_ready, wb_stall and hazard_stall are combinational from inputs and registered state in the same cycle. This provides setup before the register file's negedge write.
- State, cnt and busy update at posedge clk.
- A busy bit set at edge N stalls readers from cycle N onward. Readers are released the cycle after the completing handshake.
- **Reset:**
  - While rst=1: we=0, lu_ready=0, wb_stall=0, hazard_stall=0.
  - At the reset edge: state←IDLE, cnt←0, busy←0.
  - Reset mid-WAIT/FORCE discards the pending grant. The long-latency unit keeps lu_valid high and is served after reset.
- Worst-case latency from lu_valid to accept is STARVE_LIMIT+1 cycles.

## Test plan
- **Idle grant:** lu_valid=1, lu_waddr=7, lu_wdata=0xDEADBEEF, wb_we=0 → same cycle lu_ready=1, we=1, waddr=7, wdata=0xDEADBEEF.
- **Conflict priority:** wb_we=1, wb_waddr=3 and lu_valid=1, lu_waddr=5 together → writeback writes r3, lu_ready=0, state WAIT. Dropping wb_we next cycle → lu_ready=1, r5 written, state IDLE.
- **Starvation (STARVE_LIMIT=4):** wb_active held every cycle with lu_valid=1 → refused for 4 cycles. On the 5th cycle wb_stall=1, lu_ready=1, lu_* written. The 6th cycle returns to writeback priority with wb_stall=0.
- **Scoreboard:** lu_issue to r9. Then re1=1, raddr_1=9 → hazard_stall=1 every cycle until the r9 handshake. hazard_stall=0 the following cycle. dst_chk with dst_addr=9 also stalls meanwhile.
- **Set/clear collision and r0:** issue r4 in the same cycle that r4 completes → busy[4] stays 1. lu_issue to r0 → never stalls. lu_waddr=0 → lu_ready=1, we=0.
- **Reset mid-WAIT:** assert rst with cnt=2 → all outputs 0 during reset. Afterwards busy=0, cnt=0, and the held lu_valid is granted on the first cycle without wb_active.
